// File: rtl/timestamp_logger_pkg.sv
// Shared command codes, widths and FSM state type for the timestamp logger.
package timestamp_logger_pkg;

  // commandUnit command bus encoding, shared with the timestamper stage
  localparam logic [3:0] COMM_NOP    = 4'h0;
  localparam logic [3:0] COMM_FINISH = 4'h1;
  localparam logic [3:0] COMM_SAMPLE = 4'h2;

  localparam int TS_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/timestamp_logger_if.sv
// Command/timestamp input bus plus the valid/ready readout stream.
interface timestamp_logger_if #(parameter int TAG_W = 8);
  import timestamp_logger_pkg::*;

  logic [3:0]            command;
  logic [TAG_W-1:0]      tag;
  logic [TS_W-1:0]       timestamp;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [TAG_W+TS_W-1:0] rd_data;

  modport master (output command, tag, timestamp, rd_ready,
                  input  rd_valid, rd_data);
  modport slave  (input  command, tag, timestamp, rd_ready,
                  output rd_valid, rd_data);
endinterface

// File: rtl/timestamp_logger_ts_fifo.sv
// First-word fall-through FIFO; push while full is accepted only if a pop
// frees a slot in the same cycle. clr_i empties it without touching storage.
module ts_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 72
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign level_o = level_q;
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // pointers wrap naturally at DEPTH (power of two); level tracks occupancy
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // storage write; contents are don't-care until a push lands
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/timestamp_logger.sv
// Session FSM that captures tagged timestamps into a FWFT FIFO for host readout.
module timestamp_logger
  import timestamp_logger_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TAG_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  output logic                   done_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  timestamp_logger_if.slave      bus
);
  localparam int RW = TAG_W + TS_W;

  state_e           state_q, state_d;
  logic             push, fin, clr, pop, full, empty;
  logic             overflow_q;
  logic [TAG_W-1:0] push_tag;
  logic [RW-1:0]    push_data;

  assign pop        = bus.rd_valid && bus.rd_ready;
  assign push_tag   = fin ? {TAG_W{1'b1}} : bus.tag;
  assign push_data  = {push_tag, bus.timestamp};
  assign bus.rd_valid = !empty;
  assign overflow_o = overflow_q;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next-state: a FINISH leaves RUN even when its record is dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_RUN;
      ST_RUN:   if (bus.command == COMM_FINISH) state_d = ST_DRAIN;
      ST_DRAIN: if (level_o == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // outputs / datapath controls per state
  always_comb begin
    done_o = 1'b0;
    clr    = 1'b0;
    push   = 1'b0;
    fin    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        done_o = 1'b1;
        clr    = start_i;
      end
      ST_RUN: begin
        fin  = (bus.command == COMM_FINISH);
        push = (bus.command == COMM_SAMPLE) || fin;
      end
      default: ;
    endcase
  end

  // sticky drop flag, cleared only by an accepted start
  always_ff @(posedge clk) begin
    if (!rst_n || clr)              overflow_q <= 1'b0;
    else if (push && full && !pop)  overflow_q <= 1'b1;
  end

  ts_fifo #(.DEPTH(DEPTH), .W(RW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_data),
    .dout_o  (bus.rd_data),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level_o)
  );

endmodule

// File: tb/tb_timestamp_logger.sv
// Directed bench with a record scoreboard for timestamp_logger.
module tb_timestamp_logger;
  import timestamp_logger_pkg::*;

  localparam int DEPTH = 16;
  localparam int TAG_W = 8;
  localparam int RW    = TAG_W + 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       done, overflow;
  logic [4:0] level;

  timestamp_logger_if #(.TAG_W(TAG_W)) bus();

  timestamp_logger #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .done_o     (done),
    .level_o    (level),
    .overflow_o (overflow),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  int            nvec = 0;
  int            nerr = 0;
  logic [RW-1:0] sb [$];
  logic          movf = 1'b0;

  task automatic chk(input string nm, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", nm, obs, exp);
    end
  endtask

  // one clock: drive, check head/valid mid-cycle, update scoreboard, clock, check level/overflow
  task automatic cyc(input logic st, input logic [3:0] cmd, input logic [TAG_W-1:0] tg,
                     input logic [63:0] ts, input logic rdy, input logic pexp);
    logic             popd;
    logic [TAG_W-1:0] etag;
    start = st; bus.command = cmd; bus.tag = tg; bus.timestamp = ts; bus.rd_ready = rdy;
    #1;
    chk("rd_valid", RW'(bus.rd_valid), RW'(sb.size() != 0));
    popd = rdy && (sb.size() != 0);
    if (popd) begin
      chk("rd_data", bus.rd_data, sb[0]);
      sb.delete(0);
    end
    if (pexp) begin
      etag = (cmd == COMM_FINISH) ? {TAG_W{1'b1}} : tg;
      if (sb.size() < DEPTH) sb.push_back({etag, ts});
      else movf = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("level", RW'(level), RW'(sb.size()));
    chk("overflow", RW'(overflow), RW'(movf));
  endtask

  task automatic start_sess();
    movf = 1'b0;
    cyc(1'b1, COMM_NOP, '0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic drain_all();
    repeat (sb.size()) cyc(1'b0, COMM_NOP, '0, 64'd0, 1'b1, 1'b0);
    chk("done_drain_lag", RW'(done), RW'(0));
    cyc(1'b0, COMM_NOP, '0, 64'd0, 1'b0, 1'b0);
    chk("done_idle", RW'(done), RW'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.command = COMM_NOP; bus.tag = '0; bus.timestamp = '0; bus.rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", RW'(done), RW'(1));
    chk("rst_level", RW'(level), RW'(0));
    chk("rst_valid", RW'(bus.rd_valid), RW'(0));
    chk("rst_ovf", RW'(overflow), RW'(0));
    chk("rst_data", bus.rd_data, RW'(0));
    rst_n = 1'b1;

    // 1: three samples held, then read out in order
    start_sess();
    chk("run_done", RW'(done), RW'(0));
    cyc(1'b0, COMM_SAMPLE, 8'd1, 64'd5,  1'b0, 1'b1);
    cyc(1'b0, COMM_SAMPLE, 8'd2, 64'd9,  1'b0, 1'b1);
    cyc(1'b0, COMM_SAMPLE, 8'd3, 64'd12, 1'b0, 1'b1);
    chk("t1_level", RW'(level), RW'(3));
    chk("t1_head", bus.rd_data, {8'd1, 64'd5});
    repeat (3) cyc(1'b0, COMM_NOP, '0, 64'd0, 1'b1, 1'b0);
    chk("t1_empty", RW'(level), RW'(0));

    // 2: finish with two queued, drain, done lags empty by a cycle
    cyc(1'b0, COMM_SAMPLE, 8'd4, 64'd20, 1'b0, 1'b1);
    cyc(1'b0, COMM_SAMPLE, 8'd5, 64'd21, 1'b0, 1'b1);
    cyc(1'b0, COMM_FINISH, 8'd0, 64'd40, 1'b1, 1'b1);
    drain_all();

    // 3: overflow with 18 samples into 16 slots, finish dropped but still drains
    start_sess();
    for (int i = 0; i < 18; i++)
      cyc(1'b0, COMM_SAMPLE, 8'(16 + i), 64'(100 + i), 1'b0, 1'b1);
    chk("t3_full", RW'(level), RW'(16));
    chk("t3_ovf", RW'(overflow), RW'(1));
    cyc(1'b0, COMM_FINISH, 8'd0, 64'd200, 1'b0, 1'b1);
    drain_all();
    chk("t3_ovf_idle", RW'(overflow), RW'(1));
    start_sess();
    chk("t3_ovf_clr", RW'(overflow), RW'(0));

    // 4: push while full with a simultaneous pop is accepted
    for (int i = 0; i < 16; i++)
      cyc(1'b0, COMM_SAMPLE, 8'(64 + i), 64'(300 + i), 1'b0, 1'b1);
    cyc(1'b0, COMM_SAMPLE, 8'hA5, 64'd400, 1'b1, 1'b1);
    chk("t4_level", RW'(level), RW'(16));
    chk("t4_ovf", RW'(overflow), RW'(0));
    cyc(1'b0, COMM_FINISH, 8'd0, 64'd401, 1'b1, 1'b1);
    drain_all();

    // 5: reset mid-session drops everything
    start_sess();
    for (int i = 0; i < 5; i++)
      cyc(1'b0, COMM_SAMPLE, 8'(i + 1), 64'(500 + i), 1'b0, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    movf = 1'b0;
    chk("t5_level", RW'(level), RW'(0));
    chk("t5_valid", RW'(bus.rd_valid), RW'(0));
    chk("t5_done", RW'(done), RW'(1));
    chk("t5_ovf", RW'(overflow), RW'(0));
    cyc(1'b0, COMM_SAMPLE, 8'd7, 64'd520, 1'b0, 1'b0);
    chk("t5_ignored", RW'(done), RW'(1));

    // 6: start during RUN and samples during IDLE are ignored
    start_sess();
    cyc(1'b0, COMM_SAMPLE, 8'd8, 64'd600, 1'b0, 1'b1);
    cyc(1'b0, COMM_SAMPLE, 8'd9, 64'd601, 1'b0, 1'b1);
    cyc(1'b1, COMM_NOP, 8'd0, 64'd602, 1'b0, 1'b0);
    chk("t6_run", RW'(done), RW'(0));
    cyc(1'b0, COMM_SAMPLE, 8'd10, 64'd603, 1'b0, 1'b1);
    cyc(1'b0, COMM_FINISH, 8'd0, 64'd604, 1'b1, 1'b1);
    drain_all();
    cyc(1'b0, COMM_SAMPLE, 8'd11, 64'd610, 1'b1, 1'b0);
    chk("t6_idle_done", RW'(done), RW'(1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
